// File: rtl/gpr_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// gpr_wb_arbiter_pkg
//  Shared encodings for the GPR writeback arbiter:
//   - flag_op_e   : FlagOp encoding seen by the GPR (DIS / SET / SET_AND_WR)
//   - wb_port_e   : writeback port identifiers (A = ALU, B = load unit)
//   - REG_ADDR_FLAG : default address of the flag register
//  is_flag_write() tells whether a FlagOp updates the flag register.
// -----------------------------------------------------------------------------
package gpr_wb_arbiter_pkg;

  typedef enum logic [1:0] {
    FLAG_OP_DIS        = 2'd0,
    FLAG_OP_SET        = 2'd1,
    FLAG_OP_SET_AND_WR = 2'd2
  } flag_op_e;

  typedef enum logic {
    WB_PORT_A = 1'b0,
    WB_PORT_B = 1'b1
  } wb_port_e;

  localparam int unsigned REG_ADDR_FLAG = 5;

  function automatic logic is_flag_write(input logic [1:0] flagop);
    return (flagop == FLAG_OP_SET) || (flagop == FLAG_OP_SET_AND_WR);
  endfunction

endpackage

// File: rtl/gpr_wb_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// gpr_wb_arbiter_rr_arb2
//  Two-way round-robin grant with its last_grant flop.
//  Ports:
//   clk, reset      clock, synchronous active-high reset
//   stall_i         suppresses every grant while high
//   req_a_i/req_b_i request lines (valid of each writeback port)
//   gnt_a_o/gnt_b_o combinational one-hot grant
//   last_grant_o    port granted most recently (B after reset, so A wins first tie)
// -----------------------------------------------------------------------------
module gpr_wb_arbiter_rr_arb2
  import gpr_wb_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     stall_i,
  input  logic     req_a_i,
  input  logic     req_b_i,
  output logic     gnt_a_o,
  output logic     gnt_b_o,
  output wb_port_e last_grant_o
);

  wb_port_e last_q, last_d;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    gnt_a_o = 1'b0;
    gnt_b_o = 1'b0;
    if (!stall_i) begin
      if (req_a_i && (!req_b_i || (last_q == WB_PORT_B))) begin
        gnt_a_o = 1'b1;
      end else if (req_b_i) begin
        gnt_b_o = 1'b1;
      end
    end
  end

  // A grant always means a transfer because grants only go to valid ports.
  always_comb begin
    last_d = last_q;
    if (gnt_a_o) begin
      last_d = WB_PORT_A;
    end else if (gnt_b_o) begin
      last_d = WB_PORT_B;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= WB_PORT_B;
    end else begin
      last_q <= last_d;
    end
  end

  assign last_grant_o = last_q;

endmodule

// File: rtl/gpr_wb_arbiter.sv
// -----------------------------------------------------------------------------
// gpr_wb_arbiter
//  Shares the single GPR write port between port A (ALU) and port B (load
//  unit). The GPR inputs are driven from an output register, so an accepted
//  write commits on the edge after acceptance. A pending-write query lets
//  decode detect RAW hazards on the write held in the output register.
//
//  Handshake: x_valid is held with stable fields until x_ready; x_ready is
//  combinational (grant to x) and a transfer is x_valid & x_ready in the same
//  cycle. A requester may drop valid without ready.
//
//  Ports:
//   clk, reset                    clock, synchronous active-high reset
//   stall                         no grant while high
//   a_valid/a_ready/a_addr/a_data/a_flagop/a_nflag   port A request
//   b_valid/b_ready/b_addr/b_data/b_flagop/b_nflag   port B request
//   gpr_we/gpr_awr/gpr_din/gpr_flagop/gpr_nflag      registered GPR write
//   q_addr1/q_addr2 -> q_hit1/q_hit2                 hazard query (comb.)
// -----------------------------------------------------------------------------
module gpr_wb_arbiter
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int unsigned     DW     = 32,
  parameter int unsigned     AW     = 5,
  parameter logic [AW-1:0]   FLAG_A = AW'(REG_ADDR_FLAG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic [1:0]    a_flagop,
  input  logic [DW-1:0] a_nflag,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  input  logic [1:0]    b_flagop,
  input  logic [DW-1:0] b_nflag,
  output logic          gpr_we,
  output logic [AW-1:0] gpr_awr,
  output logic [DW-1:0] gpr_din,
  output logic [1:0]    gpr_flagop,
  output logic [DW-1:0] gpr_nflag,
  input  logic [AW-1:0] q_addr1,
  input  logic [AW-1:0] q_addr2,
  output logic          q_hit1,
  output logic          q_hit2
);

  logic     gnt_a, gnt_b;
  wb_port_e last_grant;

  gpr_wb_arbiter_rr_arb2 u_arb (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall),
    .req_a_i      (a_valid),
    .req_b_i      (b_valid),
    .gnt_a_o      (gnt_a),
    .gnt_b_o      (gnt_b),
    .last_grant_o (last_grant)
  );

  assign a_ready = gnt_a;
  assign b_ready = gnt_b;

  // Output register
  logic          we_q,     we_d;
  logic [AW-1:0] awr_q,    awr_d;
  logic [DW-1:0] din_q,    din_d;
  logic [1:0]    flagop_q, flagop_d;
  logic [DW-1:0] nflag_q,  nflag_d;

  // Without a transfer the register goes idle but keeps addr/data, so only
  // the enables toggle on idle cycles.
  always_comb begin
    we_d     = 1'b0;
    flagop_d = FLAG_OP_DIS;
    awr_d    = awr_q;
    din_d    = din_q;
    nflag_d  = nflag_q;
    if (gnt_a) begin
      we_d     = 1'b1;
      awr_d    = a_addr;
      din_d    = a_data;
      flagop_d = a_flagop;
      nflag_d  = a_nflag;
    end else if (gnt_b) begin
      we_d     = 1'b1;
      awr_d    = b_addr;
      din_d    = b_data;
      flagop_d = b_flagop;
      nflag_d  = b_nflag;
    end
  end

  // Reset wins over a transfer accepted in the same cycle: that write is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q     <= 1'b0;
      awr_q    <= '0;
      din_q    <= '0;
      flagop_q <= FLAG_OP_DIS;
      nflag_q  <= '0;
    end else begin
      we_q     <= we_d;
      awr_q    <= awr_d;
      din_q    <= din_d;
      flagop_q <= flagop_d;
      nflag_q  <= nflag_d;
    end
  end

  assign gpr_we     = we_q;
  assign gpr_awr    = awr_q;
  assign gpr_din    = din_q;
  assign gpr_flagop = flagop_q;
  assign gpr_nflag  = nflag_q;

  // A SET-only op writes no GPR data, so it only hazards on the flag
  // register. Register 0 is never a data hazard because the GPR drops it.
  function automatic logic pending_hit(input logic [AW-1:0] q);
    logic data_hit, flag_hit;
    data_hit = we_q && (flagop_q != FLAG_OP_SET) && (q == awr_q) && (q != '0);
    flag_hit = is_flag_write(flagop_q) && (q == FLAG_A);
    return data_hit || flag_hit;
  endfunction

  assign q_hit1 = pending_hit(q_addr1);
  assign q_hit2 = pending_hit(q_addr2);

  // last_grant is kept visible at this level for debug probing.
  logic unused_last_grant;
  assign unused_last_grant = (last_grant == WB_PORT_A);

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
module tb_gpr_wb_arbiter;
  import gpr_wb_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int EW = AW + DW + 2 + DW;
  localparam logic [AW-1:0] FLAG_A = 5'd5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          stall = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0, a_nflag = '0, b_nflag = '0;
  logic [1:0]    a_flagop = 2'd0, b_flagop = 2'd0;
  logic          gpr_we;
  logic [AW-1:0] gpr_awr;
  logic [DW-1:0] gpr_din, gpr_nflag;
  logic [1:0]    gpr_flagop;
  logic [AW-1:0] q_addr1 = '0, q_addr2 = '0;
  logic          q_hit1, q_hit2;

  gpr_wb_arbiter #(.DW(DW), .AW(AW), .FLAG_A(FLAG_A)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .a_flagop(a_flagop), .a_nflag(a_nflag),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .b_flagop(b_flagop), .b_nflag(b_nflag),
    .gpr_we(gpr_we), .gpr_awr(gpr_awr), .gpr_din(gpr_din),
    .gpr_flagop(gpr_flagop), .gpr_nflag(gpr_nflag),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_hit1(q_hit1), .q_hit2(q_hit2)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  logic [EW-1:0] exp_q[$];
  bit            mon_en = 1'b0;
  bit            rst_pend = 1'b1;
  bit            m_last_b = 1'b1;
  bit            acc_a = 1'b0, acc_b = 1'b0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_awr = '0;
  logic [DW-1:0] m_din = '0, m_nflag = '0;
  logic [1:0]    m_flagop = 2'd0;

  function automatic logic hit_model(input logic [AW-1:0] q);
    logic fw;
    fw = (m_flagop == 2'd1) || (m_flagop == 2'd2);
    return (m_we && (m_flagop != 2'd1) && (q == m_awr) && (q != 5'd0)) ||
           (fw && (q == FLAG_A));
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      logic ga, gb;
      // expected content of the output register this cycle
      if (rst_pend) begin
        m_we = 1'b0; m_awr = '0; m_din = '0; m_flagop = 2'd0; m_nflag = '0;
        rst_pend = 1'b0;
      end else if (exp_q.size() > 0) begin
        m_we = 1'b1;
        {m_awr, m_din, m_flagop, m_nflag} = exp_q.pop_front();
      end else begin
        m_we = 1'b0; m_flagop = 2'd0;
      end
      check("gpr_we", gpr_we, m_we);
      check("gpr_awr", gpr_awr, m_awr);
      check("gpr_din", gpr_din, m_din);
      check("gpr_flagop", gpr_flagop, m_flagop);
      check("gpr_nflag", gpr_nflag, m_nflag);
      check("q_hit1", q_hit1, hit_model(q_addr1));
      check("q_hit2", q_hit2, hit_model(q_addr2));
      // expected grant this cycle
      ga = 1'b0; gb = 1'b0;
      if (!stall) begin
        if (a_valid && (!b_valid || m_last_b)) ga = 1'b1;
        else if (b_valid) gb = 1'b1;
      end
      check("a_ready", a_ready, ga);
      check("b_ready", b_ready, gb);
      acc_a = ga; acc_b = gb;
      if (reset) begin
        exp_q.delete();
        rst_pend = 1'b1;
        m_last_b = 1'b1;
      end else if (ga) begin
        exp_q.push_back({a_addr, a_data, a_flagop, a_nflag});
        m_last_b = 1'b0;
      end else if (gb) begin
        exp_q.push_back({b_addr, b_data, b_flagop, b_nflag});
        m_last_b = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [AW-1:0] ad, input logic [DW-1:0] d,
                       input logic [1:0] fo, input logic [DW-1:0] nf);
    a_valid = v; a_addr = ad; a_data = d; a_flagop = fo; a_nflag = nf;
  endtask

  task automatic set_b(input logic v, input logic [AW-1:0] ad, input logic [DW-1:0] d,
                       input logic [1:0] fo, input logic [DW-1:0] nf);
    b_valid = v; b_addr = ad; b_data = d; b_flagop = fo; b_nflag = nf;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic idle_ports();
    a_valid = 1'b0; b_valid = 1'b0; stall = 1'b0;
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;

    // 1: single A write, latency 1
    set_a(1'b1, 5'd3, 32'h11, 2'd0, 32'h0);
    @(negedge clk); check("t1_a_ready", a_ready, 1'b1);
    step(); a_valid = 1'b0;
    @(negedge clk);
    check("t1_we", gpr_we, 1'b1);
    check("t1_awr", gpr_awr, 5'd3);
    check("t1_din", gpr_din, 32'h11);
    step();
    @(negedge clk); check("t1_we_off", gpr_we, 1'b0);
    step();

    // 2: A and B together after reset -> A,B,A,B
    do_reset();
    set_a(1'b1, 5'd1, 32'hA0, 2'd0, 32'h0);
    set_b(1'b1, 5'd2, 32'hB0, 2'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_a_ready", a_ready, (i % 2) == 0);
      check("t2_b_ready", b_ready, (i % 2) == 1);
      step();
      if (acc_a) set_a(1'b1, 5'd1, 32'hA0 + i + 1, 2'd0, 32'h0);
      if (acc_b) set_b(1'b1, 5'd2, 32'hB0 + i + 1, 2'd0, 32'h0);
    end
    idle_ports();
    step(); step();

    // 3: stall holds off B
    stall = 1'b1;
    set_b(1'b1, 5'd4, 32'h33, 2'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_b_ready_stall", b_ready, 1'b0);
      check("t3_we_stall", gpr_we, 1'b0);
      step();
    end
    stall = 1'b0;
    @(negedge clk); check("t3_b_ready", b_ready, 1'b1);
    step(); b_valid = 1'b0;
    @(negedge clk); check("t3_we", gpr_we, 1'b1);
    step();

    // 4: SET_AND_WR hazard query
    set_a(1'b1, 5'd7, 32'h77, 2'd2, 32'h1);
    step(); a_valid = 1'b0;
    q_addr1 = 5'd7; q_addr2 = FLAG_A;
    #2;
    check("t4_flagop", gpr_flagop, 2'd2);
    check("t4_hit1", q_hit1, 1'b1);
    check("t4_hit2", q_hit2, 1'b1);
    q_addr1 = 5'd0; q_addr2 = 5'd0;
    #1;
    check("t4_hit1_zero", q_hit1, 1'b0);
    check("t4_hit2_zero", q_hit2, 1'b0);
    step();

    // 5: reset after a transfer, reset during a transfer, tie after reset
    set_a(1'b1, 5'd9, 32'h99, 2'd0, 32'h0);
    step(); a_valid = 1'b0; reset = 1'b1;
    @(negedge clk); check("t5_we_before_rst", gpr_we, 1'b1);
    step(); reset = 1'b0;
    @(negedge clk); check("t5_we_after_rst", gpr_we, 1'b0);
    step();
    set_a(1'b1, 5'd10, 32'hAA, 2'd0, 32'h0); reset = 1'b1;
    step(); a_valid = 1'b0; reset = 1'b0;
    @(negedge clk); check("t5_dropped_we", gpr_we, 1'b0);
    step();
    set_a(1'b1, 5'd11, 32'h5A, 2'd0, 32'h0);
    set_b(1'b1, 5'd12, 32'h5B, 2'd0, 32'h0);
    @(negedge clk);
    check("t5_tie_a", a_ready, 1'b1);
    check("t5_tie_b", b_ready, 1'b0);
    step();

    // 6: A waits while B wins, then goes with its original data
    set_a(1'b1, 5'd13, 32'hA6, 2'd0, 32'h0);
    @(negedge clk);
    check("t6_b_wins", b_ready, 1'b1);
    check("t6_a_waits", a_ready, 1'b0);
    step(); b_valid = 1'b0;
    @(negedge clk); check("t6_a_granted", a_ready, 1'b1);
    step(); a_valid = 1'b0;
    @(negedge clk);
    check("t6_din", gpr_din, 32'hA6);
    check("t6_awr", gpr_awr, 5'd13);
    step();

    // random traffic, requesters hold fields until accepted
    for (int i = 0; i < 300; i++) begin
      if (!a_valid || acc_a) begin
        set_a($urandom_range(0, 9) < 7, AW'($urandom_range(0, 31)), $urandom,
              2'($urandom_range(0, 2)), $urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        a_valid = 1'b0;
      end
      if (!b_valid || acc_b) begin
        set_b($urandom_range(0, 9) < 7, AW'($urandom_range(0, 31)), $urandom,
              2'($urandom_range(0, 2)), $urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        b_valid = 1'b0;
      end
      stall   = ($urandom_range(0, 99) < 15);
      reset   = ($urandom_range(0, 99) == 0);
      q_addr1 = ($urandom_range(0, 1) == 0) ? gpr_awr : AW'($urandom_range(0, 31));
      q_addr2 = ($urandom_range(0, 3) == 0) ? FLAG_A  : AW'($urandom_range(0, 31));
      step();
    end
    idle_ports();
    reset = 1'b0;
    step(); step(); step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
